// File: rtl/pgen_pkg.sv
// Shared constants, state encoding and LFSR helper for the pipeline pattern generator.
// The LFSR constants are only consumed when PGEN_LFSR_FILL_EN is defined.
package pgen_pkg;

    localparam int DATA_W    = 64;
    localparam int CTRL_W    = 8;
    localparam int LEN_W     = 8;
    localparam int PAT_BYTES = 7;
    localparam int POS_W     = LEN_W + 3;

    localparam logic [CTRL_W-1:0] SOP_CTRL = 8'hFF;

    localparam logic [DATA_W-1:0] LFSR_SEED = 64'h0123_4567_89AB_CDEF;
    // Fibonacci taps 64,63,61,60 expressed as zero-based bits 63,62,60,59.
    localparam logic [DATA_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
        return {s[DATA_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pgen_lfsr64.sv
// 64-bit Fibonacci LFSR supplying filler bytes; q is the filler of the word on pipe0.
// Instantiated by pipe_pattern_gen only when PGEN_LFSR_FILL_EN is defined.
module pgen_lfsr64
    import pgen_pkg::*;
(
    input  logic              clk,
    input  logic              mrst,
    input  logic              load,
    input  logic              adv,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = LFSR_SEED;
        end else if (adv) begin
            q_d = lfsr_next(q_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (mrst) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_pattern_gen.sv
// Burst generator of {ctrl,data} pipeline words with a 7-byte pattern overlaid at any byte offset.
// Define PGEN_LFSR_FILL_EN for LFSR filler bytes; otherwise filler bytes are zero.
module pipe_pattern_gen
    import pgen_pkg::*;
(
    input  logic                     clk,
    input  logic                     mrst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic [DATA_W-1:0]        pat,
    input  logic [POS_W-1:0]         pat_pos,
    input  logic                     pat_en,
    input  logic                     ce,
    output logic [CTRL_W+DATA_W-1:0] pipe0,
    output logic                     out_vld,
    output logic                     busy,
    output logic                     done
);

    localparam int PAT_W = 8 * PAT_BYTES;
    localparam logic [POS_W:0] PAT_LEN = PAT_BYTES;

    state_e                   state_q, state_d;
    logic [LEN_W-1:0]         word_q, word_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [PAT_W-1:0]         pat_q, pat_d;
    logic [POS_W-1:0]         pos_q, pos_d;
    logic                     pen_q, pen_d;
    logic [CTRL_W+DATA_W-1:0] pipe_q, pipe_d;
    logic                     vld_q, vld_d;

    logic                     accept;
    logic                     last;
    logic                     step;
    logic [DATA_W-1:0]        fill_first;
    logic [DATA_W-1:0]        fill_next;
    logic [DATA_W-1:0]        next_data;
    logic                     unused_pat_hi;

    assign accept = (state_q == IDLE) && start && (len != '0);
    assign last   = (word_q == len_q - LEN_W'(1));
    assign step   = (state_q == SEND) && ce && !last;

    assign unused_pat_hi = ^pat[DATA_W-1:PAT_W];

`ifdef PGEN_LFSR_FILL_EN
    logic [DATA_W-1:0] lfsr_q;

    pgen_lfsr64 u_lfsr (
        .clk  (clk),
        .mrst (mrst),
        .load (accept),
        .adv  (step),
        .q    (lfsr_q)
    );

    assign fill_first = LFSR_SEED;
    assign fill_next  = lfsr_next(lfsr_q);
`else
    assign fill_first = '0;
    assign fill_next  = '0;
`endif

    // Lane b of word w is burst byte {w,b}; lane 0 is the most significant byte.
    function automatic logic [DATA_W-1:0] overlay(
        input logic [LEN_W-1:0]  w,
        input logic [PAT_W-1:0]  p,
        input logic [POS_W-1:0]  pos,
        input logic              en,
        input logic [DATA_W-1:0] fill
    );
        logic [DATA_W-1:0] d;
        logic [POS_W:0]    n;
        logic [POS_W:0]    k;
        logic [PAT_W-1:0]  sh;
        d = fill;
        for (int b = 0; b < 8; b++) begin
            n  = {1'b0, w, 3'(b)};
            k  = n - {1'b0, pos};
            sh = p << {k[2:0], 3'b000};
            if (en && (n >= {1'b0, pos}) && (k < PAT_LEN)) begin
                d[DATA_W-1-8*b -: 8] = sh[PAT_W-1 -: 8];
            end
        end
        return d;
    endfunction

    // In IDLE the word being built is word 0 from the live inputs; in SEND it is the next word.
    always_comb begin
        if (state_q == IDLE) begin
            next_data = overlay('0, pat[PAT_W-1:0], pat_pos, pat_en, fill_first);
        end else begin
            next_data = overlay(word_q + LEN_W'(1), pat_q, pos_q, pen_q, fill_next);
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        len_d   = len_q;
        pat_d   = pat_q;
        pos_d   = pos_q;
        pen_d   = pen_q;
        pipe_d  = pipe_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    word_d  = '0;
                    len_d   = len;
                    pat_d   = pat[PAT_W-1:0];
                    pos_d   = pat_pos;
                    pen_d   = pat_en;
                    pipe_d  = {SOP_CTRL, next_data};
                    vld_d   = 1'b1;
                end
            end
            SEND: begin
                if (ce) begin
                    if (last) begin
                        state_d = DONE;
                        word_d  = '0;
                        pipe_d  = '0;
                        vld_d   = 1'b0;
                    end else begin
                        word_d  = word_q + LEN_W'(1);
                        pipe_d  = {CTRL_W'(0), next_data};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mrst) begin
            state_q <= IDLE;
            word_q  <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            pos_q   <= '0;
            pen_q   <= 1'b0;
            pipe_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            pos_q   <= pos_d;
            pen_q   <= pen_d;
            pipe_q  <= pipe_d;
            vld_q   <= vld_d;
        end
    end

    assign pipe0   = pipe_q;
    assign out_vld = vld_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_pipe_pattern_gen.sv
// Randomised and directed bench for pipe_pattern_gen against a byte-array reference model.
// Build with PGEN_LFSR_FILL_EN defined to also exercise the LFSR filler.
module tb_pipe_pattern_gen;

    logic        clk = 1'b0;
    logic        mrst;
    logic        start;
    logic [7:0]  len;
    logic [63:0] pat;
    logic [10:0] pat_pos;
    logic        pat_en;
    logic        ce;
    logic [71:0] pipe0;
    logic        out_vld;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [71:0] exp_words [0:255];
    logic [71:0] obs_q [$];
    logic [71:0] ref_q [$];

    localparam logic [63:0] PAT_A = 64'h0011_2233_4455_6677;

    pipe_pattern_gen dut (
        .clk     (clk),
        .mrst    (mrst),
        .start   (start),
        .len     (len),
        .pat     (pat),
        .pat_pos (pat_pos),
        .pat_en  (pat_en),
        .ce      (ce),
        .pipe0   (pipe0),
        .out_vld (out_vld),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

`ifdef PGEN_LFSR_FILL_EN
    function automatic logic [63:0] ref_lfsr(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction
`endif

    // Expected burst: byte n is pattern byte (n-pos) inside the window, otherwise filler.
    task automatic build_model(input int l, input logic [63:0] p, input int pos, input bit en);
        logic [63:0] fill;
        fill = 64'h0;
`ifdef PGEN_LFSR_FILL_EN
        fill = 64'h0123_4567_89AB_CDEF;
`endif
        for (int w = 0; w < l; w++) begin
            logic [63:0] d;
            for (int b = 0; b < 8; b++) begin
                int n;
                logic [7:0] by;
                n  = w * 8 + b;
                by = 8'(fill >> (56 - 8 * b));
                if (en && n >= pos && n < pos + 7) by = 8'(p >> (8 * (6 - (n - pos))));
                d[63 - 8 * b -: 8] = by;
            end
            exp_words[w] = {(w == 0) ? 8'hFF : 8'h00, d};
`ifdef PGEN_LFSR_FILL_EN
            fill = ref_lfsr(fill);
`endif
        end
    endtask

    // ce_mode: 0 = ce always 1, 1 = random ce, 2 = three-cycle stall on word 1.
    task automatic run_burst(input int l, input logic [63:0] p, input int pos, input bit en,
                             input int ce_mode);
        int  idx;
        int  stalls;
        bit  finished;
        build_model(l, p, pos, en);
        obs_q.delete();
        @(negedge clk);
        len     = 8'(l);
        pat     = p;
        pat_pos = 11'(pos);
        pat_en  = en;
        start   = 1'b1;
        ce      = 1'b1;
        idx      = 0;
        stalls   = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
            @(negedge clk);
            if (idx < l) begin
                check("vld", 72'(out_vld), 72'd1);
                check("word", pipe0, exp_words[idx]);
                check("busy", 72'(busy), 72'd1);
                check("early_done", 72'(done), 72'd0);
                if (obs_q.size() == idx) obs_q.push_back(pipe0);
            end else if (idx == l) begin
                check("done_pulse", 72'(done), 72'd1);
                check("done_vld", 72'(out_vld), 72'd0);
                check("done_pipe", pipe0, 72'd0);
                check("done_busy", 72'(busy), 72'd1);
            end else begin
                check("idle_busy", 72'(busy), 72'd0);
                check("idle_done", 72'(done), 72'd0);
                finished = 1'b1;
            end
            // Scramble the request inputs; the burst in flight must ignore all of them.
            start   = finished ? 1'b0 : 1'($urandom_range(0, 1));
            len     = 8'($urandom);
            pat     = {$urandom, $urandom};
            pat_pos = 11'($urandom);
            pat_en  = 1'($urandom);
            case (ce_mode)
                1:       ce = ($urandom_range(0, 3) != 0);
                2:       if (idx == 1 && stalls < 3) begin ce = 1'b0; stalls++; end else ce = 1'b1;
                default: ce = 1'b1;
            endcase
            if (idx < l) begin
                if (ce) idx++;
            end else begin
                idx++;
            end
        end
        start = 1'b0;
        check("terminated", 72'(finished), 72'd1);
    endtask

    initial begin
        mrst = 1'b1; start = 1'b0; len = '0; pat = '0; pat_pos = '0; pat_en = 1'b0; ce = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pipe", pipe0, 72'd0);
        check("rst_vld", 72'(out_vld), 72'd0);
        check("rst_busy", 72'(busy), 72'd0);
        check("rst_done", 72'(done), 72'd0);
        mrst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 72'(busy), 72'd0);

        run_burst(4, PAT_A, 0, 1'b1, 0);
        check("basic_count", 72'(obs_q.size()), 72'd4);
`ifndef PGEN_LFSR_FILL_EN
        check("basic_w0", obs_q[0], 72'hFF_1122_3344_5566_7700);
        check("basic_w3", obs_q[3], 72'h00_0000_0000_0000_0000);
`endif

        run_burst(3, PAT_A, 13, 1'b1, 0);
`ifndef PGEN_LFSR_FILL_EN
        check("straddle_w0", obs_q[0], 72'hFF_0000_0000_0000_0000);
        check("straddle_w1", obs_q[1], 72'h00_0000_0000_0011_2233);
        check("straddle_w2", obs_q[2], 72'h00_4455_6677_0000_0000);
`endif

        run_burst(3, PAT_A, 20, 1'b1, 0);
`ifndef PGEN_LFSR_FILL_EN
        check("trunc_w2", obs_q[2], 72'h00_0000_0000_1122_3344);
`endif

        run_burst(4, PAT_A, 0, 1'b1, 2);
`ifndef PGEN_LFSR_FILL_EN
        check("stall_w0", obs_q[0], 72'hFF_1122_3344_5566_7700);
        check("stall_w1", obs_q[1], 72'h00_0000_0000_0000_0000);
`endif

        run_burst(5, {$urandom, $urandom}, 3, 1'b0, 1);
`ifndef PGEN_LFSR_FILL_EN
        check("nopat_w0", obs_q[0], 72'hFF_0000_0000_0000_0000);
        check("nopat_w2", obs_q[2], 72'h00_0000_0000_0000_0000);
`endif

        // len=0 request is ignored entirely.
        @(negedge clk);
        start = 1'b1; len = 8'd0; pat_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("len0_vld", 72'(out_vld), 72'd0);
            check("len0_busy", 72'(busy), 72'd0);
            check("len0_done", 72'(done), 72'd0);
            @(negedge clk);
        end

        // Reset in the middle of word 2 aborts the burst without a done pulse.
        build_model(4, PAT_A, 5, 1'b1);
        start = 1'b1; len = 8'd4; pat = PAT_A; pat_pos = 11'd5; pat_en = 1'b1; ce = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_w0", pipe0, exp_words[0]);
        @(negedge clk);
        check("abort_w1", pipe0, exp_words[1]);
        @(negedge clk);
        check("abort_w2", pipe0, exp_words[2]);
        mrst = 1'b1;
        @(negedge clk);
        mrst = 1'b0;
        check("abort_pipe", pipe0, 72'd0);
        check("abort_vld", 72'(out_vld), 72'd0);
        check("abort_busy", 72'(busy), 72'd0);
        check("abort_done", 72'(done), 72'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 72'(done), 72'd0);
            check("abort_no_vld", 72'(out_vld), 72'd0);
        end

        for (int i = 0; i < 40; i++) begin
            int l;
            int hi;
            l  = (i == 0) ? 255 : $urandom_range(1, 12);
            hi = (l * 8 + 8 > 2047) ? 2047 : l * 8 + 8;
            run_burst(l, {$urandom, $urandom}, $urandom_range(0, hi), 1'($urandom),
                      $urandom_range(0, 2));
        end

`ifdef PGEN_LFSR_FILL_EN
        run_burst(2, PAT_A, 0, 1'b0, 0);
        check("lfsr_w0", obs_q[0], {8'hFF, 64'h0123_4567_89AB_CDEF});
        check("lfsr_w1", obs_q[1], {8'h00, ref_lfsr(64'h0123_4567_89AB_CDEF)});
        ref_q = obs_q;
        run_burst(2, PAT_A, 0, 1'b0, 1);
        check("lfsr_rep_w0", obs_q[0], ref_q[0]);
        check("lfsr_rep_w1", obs_q[1], ref_q[1]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
